// File: rtl/sync_ram_be_init.sv
// Single-port word RAM with byte-enable writes, self-clearing INIT sequence
// and a 1- or 2-stage registered read pipeline.
module sync_ram_be_init #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_req,
  output logic                busy,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc, rd_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;

  logic [RD_LAT:1]              vld_pipe;
  logic [RD_LAT:1][DATA_W-1:0]  dat_pipe;

  assign busy      = (state_q == S_INIT);
  assign req_ready = ~busy;
  assign acc       = req_valid & req_ready;
  assign rd_acc    = acc & ~we;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_INIT: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == {ADDR_W{1'b1}}) begin
          state_d    = S_READY;
          clr_addr_d = '0;
        end
      end
      default: begin
        // A request in this same cycle is still accepted; clearing starts next cycle.
        if (init_req) begin
          state_d    = S_INIT;
          clr_addr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // One write port: the clear owns it while busy, otherwise accepted writes do.
  always_comb begin
    mem_we    = acc & we;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_be    = be;
    if (busy) begin
      mem_we    = rst_n;
      mem_addr  = clr_addr_q;
      mem_wdata = '0;
      mem_be    = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  // Data is captured at acceptance, so later writes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) dat_pipe[1] <= mem[addr];
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign rd_valid = vld_pipe[RD_LAT];
  assign rdata    = dat_pipe[RD_LAT];

endmodule
